dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: port 0 is the CPU execute stage, port 1 is the debug/DMA loader.
- Grants at most one access per cycle, using round-robin between the two ports.
- Drives the memory-side address, write data and write enable, and returns read data to the owning port after the memory's read latency.
- Sits between the CPU datapath and the data memory instance. A CPU access that is not granted in its cycle is reported as a stall.

Parameters:
- WORD_SIZE, 8, data width in bits (set from the global config).
- ADDR_SIZE, 8, address width in bits (set from the global config).
- READ_LATENCY, 1, cycles from grant to read data being valid at mem_rdata; legal values 0..2.
- CPU_PRIORITY, 0, if 1 port 0 always wins conflicts; if 0 strict round-robin.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  access request from port 0 / port 1.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  ADDR_SIZE each  access address.
- wdata0, wdata1  in  WORD_SIZE each  write data.
- gnt0, gnt1  out  1 each  request accepted this cycle (combinational).
- rvalid0, rvalid1  out  1 each  read data valid for that port.
- rdata0, rdata1  out  WORD_SIZE each  returned read data.
- cpu_stall  out  1  high when req0=1 and gnt0=0.
- mem_addr  out  ADDR_SIZE  to data memory.
- mem_wdata  out  WORD_SIZE  to data memory.
- mem_we  out  1  to data memory.
- mem_rdata  in  WORD_SIZE  from data memory.

Behaviour:
- Reset (asynchronous, active-high rst): the last-granted pointer resets to port 1, so port 0 wins the first conflict. The read pipeline is flushed. While rst is high, gnt0, gnt1, rvalid0, rvalid1, mem_we and cpu_stall are 0, and rdata0, rdata1, mem_addr and mem_wdata are 0.
- Request handshake: a requester holds req, we, addr and wdata stable until it sees gnt. gnt is a single-cycle pulse in the accept cycle. The requester may keep req high in the following cycle to issue a new access.
- Arbitration (combinational in the accept cycle):
  - Only one port requesting: that port is granted.
  - Both ports requesting, CPU_PRIORITY=1: port 0 is granted.
  - Both ports requesting, CPU_PRIORITY=0: the port not granted last is granted.
  - The pointer updates on every grant.
- Memory side:
  - Idle cycle: mem_we=0, mem_addr=0, mem_wdata=0.
  - Granted cycle: mem_addr and mem_wdata come from the granted port, and mem_we equals that port's we.
- Writes: complete in the grant cycle; no rvalid is produced.
- Reads:
  - A read granted in cycle T gives rvalid on the owning port in cycle T+READ_LATENCY, with rdata = mem_rdata in that cycle.
  - READ_LATENCY=0 means rvalid and rdata are combinational in cycle T.
  - Pipeline entries are {valid, owner}, so a back-to-back read on every cycle is sustained at full throughput.
- Return outputs: rvalid is high for exactly one cycle per read. rdata holds its last value when rvalid=0.
- Read-after-write to the same address in consecutive grants returns the new data (single-port memory ordering).
- A port may have up to READ_LATENCY reads outstanding. Returns arrive in grant order.
- Dropping req before gnt is illegal; the bench asserts this. The RTL does not recover from it.
- Reset mid-read: outstanding reads are discarded, and no rvalid is produced after rst deasserts.

Decomposition:
- Shared package `orgasmall_pkg`:
  - typedef `port_idx_t` (1 bit).
  - localparams `ARB_PORTS=2`, `PORT_CPU=0`, `PORT_DMA=1`.
  - struct `rd_tag_t` {valid, owner}.
- Sub-module `rd_return_pipe`: parameterised shift register of `rd_tag_t`, READ_LATENCY deep. It has a combinational bypass when READ_LATENCY=0 and an asynchronous reset clear.
- The round-robin pick remains inline.

Test Plan:
- Port 0 only: write 0x5A to 0x10, then read 0x10 → gnt0 in both cycles, mem_we=1 then 0, rvalid0 one cycle after the read grant, rdata0=0x5A, cpu_stall=0.
- Both ports request reads every cycle for 4 cycles, CPU_PRIORITY=0 → grants alternate 0,1,0,1; each rvalid goes to the correct port with the correct data; cpu_stall=1 in the cycles port 1 wins.
- Same contention with CPU_PRIORITY=1 → gnt0 every cycle, gnt1 never, cpu_stall=0.
- Port 1 writes 0x33 to 0x20 while port 0 reads 0x20 in the next cycle → rdata0=0x33.
- Assert rst one cycle after a read grant (READ_LATENCY=2) → no rvalid appears; after release, the first conflicting request grants port 0.
- READ_LATENCY=0 build: read 0x10 → rvalid0 and rdata0 in the grant cycle.

Source files
------------

// File: rtl/orgasmall_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   port_idx_t : identifies one of the two arbiter ports
//   rd_tag_t   : one read-return pipeline entry {valid, owner}
package orgasmall_pkg;

  localparam int ARB_PORTS = 2;
  localparam int PORT_CPU  = 0;
  localparam int PORT_DMA  = 1;

  typedef logic [0:0] port_idx_t;

  typedef struct packed {
    logic      valid;
    port_idx_t owner;
  } rd_tag_t;

  // Port that did not take the last grant; used for round-robin fairness.
  function automatic port_idx_t other_port(input port_idx_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/rd_return_pipe.sv
// Read-return tag pipeline for dmem_arbiter.
// Delays each {valid, owner} tag by DEPTH cycles so that the tag lines up
// with the memory's read data. DEPTH=0 is a straight combinational bypass.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset (clears all stages)
//   tag_in   : tag issued in the grant cycle
//   tag_out  : tag whose read data is on mem_rdata this cycle
module rd_return_pipe
  import orgasmall_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign tag_out        = tag_in;
  end else begin : g_shift
    rd_tag_t [DEPTH-1:0] stage;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage <= '0;
      end else begin
        stage[0] <= tag_in;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign tag_out = stage[DEPTH-1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Port 0 is the CPU execute stage, port 1 the debug/DMA loader. At most one
// access is granted per cycle (round-robin, or CPU-first when CPU_PRIORITY=1);
// read data is routed back to the owning port READ_LATENCY cycles later.
// Ports:
//   clk, rst                  : system clock, asynchronous active-high reset
//   req/we/addr/wdata{0,1}    : requester access (held until gnt)
//   gnt{0,1}                  : combinational accept pulse
//   rvalid{0,1}, rdata{0,1}   : read return; rdata holds when rvalid=0
//   cpu_stall                 : port 0 requesting but not granted
//   mem_addr/mem_wdata/mem_we : memory command for the granted access
//   mem_rdata                 : memory read data
module dmem_arbiter
  import orgasmall_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int ADDR_SIZE    = 8,
  parameter int READ_LATENCY = 1,
  parameter int CPU_PRIORITY = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [WORD_SIZE-1:0] rdata0,
  output logic [WORD_SIZE-1:0] rdata1,
  output logic                 cpu_stall,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam port_idx_t P_CPU = port_idx_t'(PORT_CPU);
  localparam port_idx_t P_DMA = port_idx_t'(PORT_DMA);

  port_idx_t            last_q;
  logic                 pick0;
  logic                 pick1;
  rd_tag_t              tag_in;
  rd_tag_t              tag_out;
  logic [WORD_SIZE-1:0] rdata0_q;
  logic [WORD_SIZE-1:0] rdata1_q;

  // Grants are forced low while rst is high so nothing reaches the memory.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        if (CPU_PRIORITY != 0 || other_port(last_q) == P_CPU) begin
          pick0 = 1'b1;
        end else begin
          pick1 = 1'b1;
        end
      end else begin
        pick0 = req0;
        pick1 = req1;
      end
    end
  end

  // Resetting to the DMA port makes the CPU win the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= P_DMA;
    end else if (pick0) begin
      last_q <= P_CPU;
    end else if (pick1) begin
      last_q <= P_DMA;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_in    = '0;
    if (pick0) begin
      mem_we       = we0;
      mem_addr     = addr0;
      mem_wdata    = wdata0;
      tag_in.valid = ~we0;
      tag_in.owner = P_CPU;
    end else if (pick1) begin
      mem_we       = we1;
      mem_addr     = addr1;
      mem_wdata    = wdata1;
      tag_in.valid = ~we1;
      tag_in.owner = P_DMA;
    end
  end

  rd_return_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rd_return_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign gnt0      = pick0;
  assign gnt1      = pick1;
  assign cpu_stall = ~rst & req0 & ~pick0;
  assign rvalid0   = ~rst & tag_out.valid & (tag_out.owner == P_CPU);
  assign rvalid1   = ~rst & tag_out.valid & (tag_out.owner == P_DMA);

  // Return data is live from the memory in the valid cycle and held after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= mem_rdata;
      if (rvalid1) rdata1_q <= mem_rdata;
    end
  end

  assign rdata0 = rvalid0 ? mem_rdata : rdata0_q;
  assign rdata1 = rvalid1 ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. Four builds run side by side:
//   cfg0: READ_LATENCY=1, round-robin   cfg1: READ_LATENCY=1, CPU priority
//   cfg2: READ_LATENCY=2, round-robin   cfg3: READ_LATENCY=0, round-robin
// Each build has its own memory model and its own reference model.
module tb_dmem_arbiter;

  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req0 [NC], req1 [NC], we0 [NC], we1 [NC];
  logic [7:0] addr0 [NC], addr1 [NC], wdata0 [NC], wdata1 [NC];
  logic       gnt0 [NC], gnt1 [NC], rvalid0 [NC], rvalid1 [NC];
  logic       cpu_stall [NC], mem_we [NC];
  logic [7:0] rdata0 [NC], rdata1 [NC], mem_addr [NC], mem_wdata [NC], mem_rdata [NC];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  function automatic int cfg_lat(input int c);
    return (c == 2) ? 2 : ((c == 3) ? 0 : 1);
  endfunction

  function automatic int cfg_cp(input int c);
    return (c == 1) ? 1 : 0;
  endfunction

  for (genvar g = 0; g < NC; g++) begin : g_cfg
    localparam int LAT = (g == 2) ? 2 : ((g == 3) ? 0 : 1);
    localparam int CP  = (g == 1) ? 1 : 0;

    dmem_arbiter #(
      .WORD_SIZE    (8),
      .ADDR_SIZE    (8),
      .READ_LATENCY (LAT),
      .CPU_PRIORITY (CP)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0[g]),
      .req1      (req1[g]),
      .we0       (we0[g]),
      .we1       (we1[g]),
      .addr0     (addr0[g]),
      .addr1     (addr1[g]),
      .wdata0    (wdata0[g]),
      .wdata1    (wdata1[g]),
      .gnt0      (gnt0[g]),
      .gnt1      (gnt1[g]),
      .rvalid0   (rvalid0[g]),
      .rvalid1   (rvalid1[g]),
      .rdata0    (rdata0[g]),
      .rdata1    (rdata1[g]),
      .cpu_stall (cpu_stall[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_we    (mem_we[g]),
      .mem_rdata (mem_rdata[g])
    );

    // Single-port memory: registered read path of LAT stages.
    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] rd_pipe [2] = '{default: 8'h00};
    always @(posedge clk) begin
      if (mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
      rd_pipe[0] <= mem[mem_addr[g]];
      rd_pipe[1] <= rd_pipe[0];
    end
    if (LAT == 0) begin : g_comb
      assign mem_rdata[g] = mem[mem_addr[g]];
    end else begin : g_reg
      assign mem_rdata[g] = rd_pipe[LAT-1];
    end

    // A requester that was refused must still be requesting next cycle.
    logic held0 = 1'b0;
    logic held1 = 1'b0;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        held0 <= 1'b0;
        held1 <= 1'b0;
      end else begin
        held0 <= req0[g] && !gnt0[g];
        held1 <= req1[g] && !gnt1[g];
      end
    end
    always @(negedge clk) begin
      if (!rst && (held0 || held1)) begin
        n_checks++;
        assert ((!held0 || req0[g] === 1'b1) && (!held1 || req1[g] === 1'b1))
        else begin
          n_err++;
          $error("FAIL req_dropped cfg%0d cyc%0d: req0=%b req1=%b required held", g, cyc, req0[g], req1[g]);
        end
      end
    end
  end

  // Reference model state
  int         m_last [NC];
  bit         m_pend0 [NC], m_pend1 [NC];
  logic [7:0] m_mem [NC][256];
  bit         s_valid [NC][4];
  int         s_owner [NC][4];
  logic [7:0] s_data [NC][4];
  logic [7:0] m_rd0 [NC], m_rd1 [NC];

  // Proposed next access per port, shared by all builds
  logic       p_req0, p_we0, p_req1, p_we1;
  logic [7:0] p_addr0, p_wdata0, p_addr1, p_wdata1;

  task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s cfg%0d cyc%0d: observed %h expected %h", tag, c, cyc, obs, exp);
    end
  endtask

  task automatic prop(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                      input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    p_req0 = r0; p_we0 = w0; p_addr0 = a0; p_wdata0 = d0;
    p_req1 = r1; p_we1 = w1; p_addr1 = a1; p_wdata1 = d1;
  endtask

  // A refused access is re-presented unchanged until it is accepted.
  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      if (!m_pend0[c]) begin
        req0[c] = p_req0; we0[c] = p_we0; addr0[c] = p_addr0; wdata0[c] = p_wdata0;
      end
      if (!m_pend1[c]) begin
        req1[c] = p_req1; we1[c] = p_we1; addr1[c] = p_addr1; wdata1[c] = p_wdata1;
      end
    end
  endtask

  task automatic check_cycle();
    for (int c = 0; c < NC; c++) begin
      int         w;
      int         slot;
      logic       e_we, e_rv0, e_rv1;
      logic [7:0] e_addr, e_wdata;
      w = -1;
      if (rst) begin
        m_last[c] = 1; m_pend0[c] = 0; m_pend1[c] = 0; m_rd0[c] = 8'h00; m_rd1[c] = 8'h00;
        for (int k = 0; k < 4; k++) s_valid[c][k] = 0;
      end else if (req0[c] && req1[c]) begin
        w = (cfg_cp(c) == 1) ? 0 : ((m_last[c] == 0) ? 1 : 0);
      end else if (req0[c]) begin
        w = 0;
      end else if (req1[c]) begin
        w = 1;
      end
      e_we = 1'b0; e_addr = 8'h00; e_wdata = 8'h00;
      if (w == 0) begin
        e_we = we0[c]; e_addr = addr0[c]; e_wdata = wdata0[c];
      end else if (w == 1) begin
        e_we = we1[c]; e_addr = addr1[c]; e_wdata = wdata1[c];
      end
      if (w >= 0 && !e_we) begin
        slot = (cyc + cfg_lat(c)) % 4;
        s_valid[c][slot] = 1;
        s_owner[c][slot] = w;
        s_data[c][slot]  = m_mem[c][e_addr];
      end
      slot  = cyc % 4;
      e_rv0 = s_valid[c][slot] && s_owner[c][slot] == 0;
      e_rv1 = s_valid[c][slot] && s_owner[c][slot] == 1;
      if (e_rv0) m_rd0[c] = s_data[c][slot];
      if (e_rv1) m_rd1[c] = s_data[c][slot];
      s_valid[c][slot] = 0;
      if (w >= 0 && e_we) m_mem[c][e_addr] = e_wdata;

      chk("gnt0",      c, {7'd0, gnt0[c]},      {7'd0, w == 0});
      chk("gnt1",      c, {7'd0, gnt1[c]},      {7'd0, w == 1});
      chk("cpu_stall", c, {7'd0, cpu_stall[c]}, {7'd0, !rst && req0[c] && w != 0});
      chk("mem_we",    c, {7'd0, mem_we[c]},    {7'd0, e_we});
      chk("mem_addr",  c, mem_addr[c],  e_addr);
      chk("mem_wdata", c, mem_wdata[c], e_wdata);
      chk("rvalid0",   c, {7'd0, rvalid0[c]},   {7'd0, e_rv0});
      chk("rvalid1",   c, {7'd0, rvalid1[c]},   {7'd0, e_rv1});
      chk("rdata0",    c, rdata0[c], m_rd0[c]);
      chk("rdata1",    c, rdata1[c], m_rd1[c]);

      if (!rst) begin
        m_pend0[c] = req0[c] && w != 0;
        m_pend1[c] = req1[c] && w != 1;
        if (w >= 0) m_last[c] = w;
      end
    end
  endtask

  task automatic step();
    drive();
    #4;
    check_cycle();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      for (int a = 0; a < 256; a++) m_mem[c][a] = 8'h00;
      for (int k = 0; k < 4; k++) begin s_valid[c][k] = 0; s_owner[c][k] = 0; s_data[c][k] = 8'h00; end
      m_last[c] = 1; m_pend0[c] = 0; m_pend1[c] = 0; m_rd0[c] = 8'h00; m_rd1[c] = 8'h00;
    end
    prop(1, 0, 8'h10, 8'h00, 1, 1, 8'h20, 8'h77);
    @(posedge clk);
    #1;

    // Requests during reset must be ignored
    step(); adv();
    step(); adv();
    rst = 1'b0;
    prop(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    step(); adv();

    // Port 0 write then read of 0x10
    prop(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00);
    step();
    chk("d_wr_gnt0", 0, {7'd0, gnt0[0]}, 8'h01);
    chk("d_wr_we", 0, {7'd0, mem_we[0]}, 8'h01);
    adv();
    prop(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    step();
    chk("d_rd_gnt0", 0, {7'd0, gnt0[0]}, 8'h01);
    chk("d_rd_we", 0, {7'd0, mem_we[0]}, 8'h00);
    chk("d_l0_rvalid0", 3, {7'd0, rvalid0[3]}, 8'h01);
    chk("d_l0_rdata0", 3, rdata0[3], 8'h5A);
    adv();
    prop(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    step();
    chk("d_l1_rvalid0", 0, {7'd0, rvalid0[0]}, 8'h01);
    chk("d_l1_rdata0", 0, rdata0[0], 8'h5A);
    chk("d_stall", 0, {7'd0, cpu_stall[0]}, 8'h00);
    adv();
    step();
    chk("d_l2_rvalid0", 2, {7'd0, rvalid0[2]}, 8'h01);
    chk("d_hold_rdata0", 0, rdata0[0], 8'h5A);
    adv();

    // Port 1 writes 0x33 to 0x20, port 0 reads it next cycle
    prop(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h33);
    step(); adv();
    prop(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
    step(); adv();
    prop(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    step();
    chk("d_raw_rdata0", 0, rdata0[0], 8'h33);
    adv();
    step(); adv();

    // Leave port 1 as last granted, then contend for 4 cycles
    prop(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
    step(); adv();
    prop(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("d_rr_gnt0", 0, {7'd0, gnt0[0]}, (k % 2 == 0) ? 8'h01 : 8'h00);
      chk("d_rr_stall", 0, {7'd0, cpu_stall[0]}, (k % 2 == 1) ? 8'h01 : 8'h00);
      chk("d_pri_gnt0", 1, {7'd0, gnt0[1]}, 8'h01);
      chk("d_pri_gnt1", 1, {7'd0, gnt1[1]}, 8'h00);
      chk("d_pri_stall", 1, {7'd0, cpu_stall[1]}, 8'h00);
      adv();
    end
    prop(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin step(); adv(); end

    // Reset one cycle after a read grant discards the read
    prop(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    step(); adv();
    rst = 1'b1;
    prop(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    step();
    chk("d_rst_rvalid0", 2, {7'd0, rvalid0[2]}, 8'h00);
    adv();
    rst = 1'b0;
    step();
    chk("d_post_rvalid0", 2, {7'd0, rvalid0[2]}, 8'h00);
    adv();
    step(); adv();
    prop(1, 0, 8'h11, 8'h00, 1, 0, 8'h12, 8'h00);
    step();
    chk("d_first_conflict", 0, {7'd0, gnt0[0]}, 8'h01);
    chk("d_first_conflict", 2, {7'd0, gnt0[2]}, 8'h01);
    adv();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      prop($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'h10 + 8'($urandom_range(0, 7)), 8'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'h10 + 8'($urandom_range(0, 7)), 8'($urandom));
      step(); adv();
    end
    rst = 1'b0;
    prop(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin step(); adv(); end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
